tpm_wb_regs: RTL and testbench

//  Wishbone slave holding the TPM<->SoC communication registers (0xF0000000 window) for the NEORV32 core.

---
 rtl/tpm_wb_regs.sv | 161 ++++++++++++++++
 tb/tb_tpm_wb_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpm_wb_regs.sv
// Wishbone register window between the TPM host-bus logic and the NEORV32 core (wb_clk domain only).
// Optional feature macro TPM_REGS_IRQ_LATCH_EN: latched IRQ_PEND (RW1C) / IRQ_EN (RW) at 0x10 / 0x14.
module tpm_wb_regs #(
    parameter int          TPM_RAM_ADDR_WIDTH   = 11,
    parameter int          COMPLETE_PULSE_WIDTH = 20,
    parameter int          SYNC_STAGES          = 2,
    parameter logic [31:0] DEFAULT_READ_VALUE   = 32'hBADFABAC
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    wb_adr_i,
    input  logic [31:0]                   wb_dat_i,
    output logic [31:0]                   wb_dat_o,
    input  logic                          wb_we_i,
    input  logic [3:0]                    wb_sel_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_cyc_i,
    output logic                          wb_ack_o,
    input  logic                          exec_i,
    input  logic                          abort_i,
    input  logic [3:0]                    op_type_i,
    input  logic [3:0]                    locality_i,
    input  logic [TPM_RAM_ADDR_WIDTH-1:0] buf_len_i,
    output logic                          complete_o,
    output logic                          irq_o
);

    localparam logic [5:0] A_STATUS   = 6'h00;
    localparam logic [5:0] A_OP_TYPE  = 6'h01;
    localparam logic [5:0] A_LOCALITY = 6'h02;
    localparam logic [5:0] A_BUF_SIZE = 6'h03;
    localparam logic [5:0] A_IRQ_PEND = 6'h04;
    localparam logic [5:0] A_IRQ_EN   = 6'h05;
    localparam logic [5:0] A_COMPLETE = 6'h10;

    logic [SYNC_STAGES-1:0]        r_exec_sync;
    logic [SYNC_STAGES-1:0]        r_abort_sync;
    logic                          r_exec_d;
    logic                          w_exec_s;
    logic                          w_abort_s;
    logic                          w_exec_rise;
    logic [3:0]                    r_op_type;
    logic [3:0]                    r_locality;
    logic [TPM_RAM_ADDR_WIDTH-1:0] r_buf_len;
    logic [7:0]                    r_cnt;
    logic                          r_irq;
    logic                          w_ack_nxt;
    logic                          w_wr;
    logic                          w_complete;
    logic [5:0]                    w_reg;
    logic [31:0]                   w_rdata;
    logic                          w_unused;

    // Byte lanes and sub-word address bits carry no meaning here: every register is word-wide.
    assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[1:0], wb_dat_i};

    assign w_exec_s    = r_exec_sync[SYNC_STAGES-1];
    assign w_abort_s   = r_abort_sync[SYNC_STAGES-1];
    assign w_exec_rise = w_exec_s & ~r_exec_d;
    assign w_reg       = wb_adr_i[7:2];
    assign w_ack_nxt   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign w_wr        = w_ack_nxt & wb_we_i;
    assign w_complete  = (r_cnt != 8'd0);
    assign complete_o  = w_complete;
    assign irq_o       = r_irq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exec_sync  <= '0;
            r_abort_sync <= '0;
            r_exec_d     <= 1'b0;
        end else begin
            r_exec_sync  <= {r_exec_sync[SYNC_STAGES-2:0], exec_i};
            r_abort_sync <= {r_abort_sync[SYNC_STAGES-2:0], abort_i};
            r_exec_d     <= w_exec_s;
        end
    end

    // Command info is only guaranteed stable around the exec edge, so capture it exactly once there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op_type  <= '0;
            r_locality <= '0;
            r_buf_len  <= '0;
        end else if (w_exec_rise) begin
            r_op_type  <= op_type_i;
            r_locality <= locality_i;
            r_buf_len  <= buf_len_i;
        end
    end

`ifdef TPM_REGS_IRQ_LATCH_EN
    logic       r_abort_d;
    logic [1:0] r_irq_pend;
    logic [1:0] r_irq_en;
    logic [1:0] w_rise;
    logic [1:0] w_clr;

    assign w_rise = {w_abort_s & ~r_abort_d, w_exec_rise};
    assign w_clr  = (w_wr && (w_reg == A_IRQ_PEND)) ? wb_dat_i[1:0] : 2'b00;

    // A fresh edge in the same cycle as its W1C keeps the bit set, so no event is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_abort_d  <= 1'b0;
            r_irq_pend <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_abort_d  <= w_abort_s;
            r_irq_pend <= w_rise | (r_irq_pend & ~w_clr);
            if (w_wr && (w_reg == A_IRQ_EN))
                r_irq_en <= wb_dat_i[1:0];
            r_irq      <= |(r_irq_pend & r_irq_en);
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) r_irq <= 1'b0;
        else       r_irq <= w_exec_s;
    end
`endif

    always_comb begin
        w_rdata = DEFAULT_READ_VALUE;
        case (w_reg)
            A_STATUS:   w_rdata = {29'b0, w_complete, w_abort_s, w_exec_s};
            A_OP_TYPE:  w_rdata = {28'b0, r_op_type};
            A_LOCALITY: w_rdata = {28'b0, r_locality};
            A_BUF_SIZE: w_rdata = {{(32-TPM_RAM_ADDR_WIDTH){1'b0}}, r_buf_len};
            A_COMPLETE: w_rdata = 32'h0;
`ifdef TPM_REGS_IRQ_LATCH_EN
            A_IRQ_PEND: w_rdata = {30'b0, r_irq_pend};
            A_IRQ_EN:   w_rdata = {30'b0, r_irq_en};
`endif
            default:    w_rdata = DEFAULT_READ_VALUE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= w_ack_nxt;
            if (w_ack_nxt)
                wb_dat_o <= w_rdata;
        end
    end

    // A write during an active pulse is dropped rather than restarting it.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_cnt <= 8'd0;
        else if (w_wr && (w_reg == A_COMPLETE) && !w_complete)
            r_cnt <= 8'(COMPLETE_PULSE_WIDTH);
        else if (w_complete)
            r_cnt <= r_cnt - 8'd1;
    end

endmodule

// File: tb/tb_tpm_wb_regs.sv
// Self-checking bench for tpm_wb_regs: vector table, hand sequences and randomized traffic vs. a model.
module tb_tpm_wb_regs;
    localparam int          AW  = 11;
    localparam int          PW  = 20;
    localparam int          SS  = 2;
    localparam logic [31:0] DEF = 32'hBADFABAC;
`ifdef TPM_REGS_IRQ_LATCH_EN
    localparam logic [31:0] E10 = 32'h1;
    localparam logic [31:0] E14 = 32'h0;
`else
    localparam logic [31:0] E10 = DEF;
    localparam logic [31:0] E14 = DEF;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [7:0]    wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_we_i = 1'b0;
    logic [3:0]    wb_sel_i = 4'hF;
    logic          wb_stb_i = 1'b0;
    logic          wb_cyc_i = 1'b0;
    logic          wb_ack_o;
    logic          exec_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [3:0]    op_type_i = '0;
    logic [3:0]    locality_i = '0;
    logic [AW-1:0] buf_len_i = '0;
    logic          complete_o;
    logic          irq_o;

    tpm_wb_regs #(
        .TPM_RAM_ADDR_WIDTH(AW), .COMPLETE_PULSE_WIDTH(PW),
        .SYNC_STAGES(SS), .DEFAULT_READ_VALUE(DEF)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .exec_i(exec_i), .abort_i(abort_i),
        .op_type_i(op_type_i), .locality_i(locality_i), .buf_len_i(buf_len_i),
        .complete_o(complete_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int            pulse_start = -1000;
    bit            mon_en = 1'b0;
    logic          m_exec = 1'b0, m_abort = 1'b0;
    logic [3:0]    m_op = '0, m_loc = '0;
    logic [AW-1:0] m_len = '0;
    logic [1:0]    m_pend = '0, m_en = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic logic complete_at(input int n);
        return (n >= pulse_start) && (n < pulse_start + PW);
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] adr, input int e);
        case (adr[7:2])
            6'h00: return {29'b0, complete_at(e - 1), m_abort, m_exec};
            6'h01: return {28'b0, m_op};
            6'h02: return {28'b0, m_loc};
            6'h03: return 32'(m_len);
            6'h10: return 32'h0;
`ifdef TPM_REGS_IRQ_LATCH_EN
            6'h04: return {30'b0, m_pend};
            6'h05: return {30'b0, m_en};
`endif
            default: return DEF;
        endcase
    endfunction

    // complete_o is checked every cycle against the pulse window of the model
    always @(posedge clk) begin
        #2;
        if (mon_en) check("complete_o", 32'(complete_o), 32'(complete_at(ncyc)));
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic xfer(input logic [7:0] adr, input logic we, input logic [31:0] wd,
                        output logic [31:0] rd, output int ack_edge);
        int lat;
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = wd; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!wb_ack_o && lat < 8);
        check("ack_latency", 32'(lat), 32'd1);
        rd = wb_dat_o;
        ack_edge = ncyc;
        if (we && wb_ack_o) begin
            if (adr[7:2] == 6'h10 && !complete_at(ack_edge - 1)) pulse_start = ack_edge;
`ifdef TPM_REGS_IRQ_LATCH_EN
            if (adr[7:2] == 6'h04) m_pend = m_pend & ~wd[1:0];
            if (adr[7:2] == 6'h05) m_en = wd[1:0];
`endif
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        step(1);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] adr);
        logic [31:0] rd;
        int e;
        xfer(adr, 1'b0, 32'h0, rd, e);
        check(name, rd, exp_read(adr, e));
    endtask

    task automatic wait_idle();
        int g = 0;
        while (complete_o && g < 60) begin step(1); g++; end
        check("pulse_idle", 32'(complete_o), 32'd0);
    endtask

    task automatic new_cmd(input logic [3:0] op, input logic [3:0] loc,
                           input logic [AW-1:0] len, input logic ab);
        exec_i = 1'b0; abort_i = ab;
        step(SS + 3);
        m_exec = 1'b0;
        if (ab && !m_abort) m_pend[1] = 1'b1;
        m_abort = ab;
`ifndef TPM_REGS_IRQ_LATCH_EN
        check("irq_level_low", 32'(irq_o), 32'd0);
`endif
        op_type_i = op; locality_i = loc; buf_len_i = len; exec_i = 1'b1;
        step(SS + 3);
        m_exec = 1'b1; m_op = op; m_loc = loc; m_len = len; m_pend[0] = 1'b1;
`ifdef TPM_REGS_IRQ_LATCH_EN
        check("irq_latched", 32'(irq_o), 32'(|(m_pend & m_en)));
`else
        check("irq_level_high", 32'(irq_o), 32'd1);
`endif
    endtask

    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [31:0] rd;
        int e, e1, g;
        logic [7:0] alist[8];
        logic [7:0] rolist[5];
        logic [7:0] adr;
        alist  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h40};
        rolist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h20};

        vt[0]  = '{8'h04, 1'b0, 32'h0,        1'b1, 32'h3};
        vt[1]  = '{8'h08, 1'b0, 32'h0,        1'b1, 32'h5};
        vt[2]  = '{8'h0C, 1'b0, 32'h0,        1'b1, 32'h123};
        vt[3]  = '{8'h20, 1'b0, 32'h0,        1'b1, DEF};
        vt[4]  = '{8'h00, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[5]  = '{8'h00, 1'b0, 32'h0,        1'b1, 32'h1};
        vt[6]  = '{8'h04, 1'b1, 32'h0000000C, 1'b0, 32'h0};
        vt[7]  = '{8'h04, 1'b0, 32'h0,        1'b1, 32'h3};
        vt[8]  = '{8'h40, 1'b0, 32'h0,        1'b1, 32'h0};
        vt[9]  = '{8'h3C, 1'b0, 32'h0,        1'b1, DEF};
        vt[10] = '{8'hFC, 1'b0, 32'h0,        1'b1, DEF};
        vt[11] = '{8'h10, 1'b0, 32'h0,        1'b1, E10};
        vt[12] = '{8'h14, 1'b0, 32'h0,        1'b1, E14};

        // Reset state
        step(3);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_complete", 32'(complete_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        rst_i = 1'b0;
        mon_en = 1'b1;
        rd_chk("rst_status", 8'h00);
        rd_chk("rst_op", 8'h04);
        rd_chk("rst_buf", 8'h0C);

        // Vector table
        new_cmd(4'h3, 4'h5, 11'h123, 1'b0);
        for (int i = 0; i < 13; i++) begin
            xfer(vt[i].adr, vt[i].we, vt[i].wd, rd, e);
            if (vt[i].chk) check($sformatf("vec%0d_adr%h", i, vt[i].adr), rd, vt[i].exp);
        end

        // Back-to-back strobes acknowledge every other cycle
        wb_adr_i = 8'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("b2b_ack%0d", i), 32'(wb_ack_o), 32'((i % 2) == 0));
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step(1);

        // Synchroniser latency and snapshot hold
        exec_i = 1'b0; step(SS + 3);
        op_type_i = 4'h9; exec_i = 1'b1;
        step(1);
        xfer(8'h00, 1'b0, 32'h0, rd, e);
        check("status_exec_early", 32'(rd[0]), 32'd0);
        exec_i = 1'b0; step(SS + 3);
        exec_i = 1'b1;
        step(2);
        xfer(8'h00, 1'b0, 32'h0, rd, e);
        check("status_exec_sync", 32'(rd[0]), 32'd1);
        step(3);
        m_exec = 1'b1; m_op = 4'h9; m_pend[0] = 1'b1;
        op_type_i = 4'hA;
        step(3);
        rd_chk("op_held", 8'h04);

        // Complete pulse width, no restart on a second write
        wait_idle();
        xfer(8'h40, 1'b1, 32'h1, rd, e1);
        step(3);
        xfer(8'h40, 1'b1, 32'h1, rd, e);
        g = 0;
        while (complete_o && g < 60) begin step(1); g++; end
        check("pulse_width", 32'(ncyc - e1), 32'(PW));

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: xfer(8'h40, 1'b1, $urandom, rd, e);
                1: new_cmd(4'($urandom), 4'($urandom), AW'($urandom), 1'($urandom));
                2: begin
                    if ($urandom_range(0, 3) == 0) adr = {6'($urandom), 2'b00};
                    else adr = alist[$urandom_range(0, 7)];
                    rd_chk($sformatf("rand_rd_%h", adr), adr);
                end
                default: begin
                    adr = rolist[$urandom_range(0, 4)];
                    xfer(adr, 1'b1, $urandom, rd, e);
                    rd_chk($sformatf("ro_rd_%h", adr), adr);
                end
            endcase
        end

`ifdef TPM_REGS_IRQ_LATCH_EN
        xfer(8'h14, 1'b1, 32'h1, rd, e);
        xfer(8'h10, 1'b1, 32'h3, rd, e);
        step(2);
        check("irq_cleared", 32'(irq_o), 32'd0);
        new_cmd(4'h1, 4'h2, 11'h10, m_abort);
        xfer(8'h10, 1'b1, 32'h1, rd, e);
        step(1);
        check("irq_w1c", 32'(irq_o), 32'd0);
        exec_i = 1'b0; step(SS + 3);
        exec_i = 1'b1;
        step(2);
        xfer(8'h10, 1'b1, 32'h1, rd, e);
        m_pend[0] = 1'b1;
        rd_chk("pend_set_wins", 8'h10);
        xfer(8'h14, 1'b1, 32'hFFFFFFFF, rd, e);
        rd_chk("irq_en_rw", 8'h14);
`endif

        // Reset in the middle of a pulse with a strobe held
        exec_i = 1'b0; abort_i = 1'b0;
        step(SS + 3);
        wait_idle();
        xfer(8'h40, 1'b1, 32'h1, rd, e1);
        while (ncyc < e1 + 9) step(1);
        mon_en = 1'b0;
        rst_i = 1'b1; wb_adr_i = 8'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("rst_mid_ack%0d", i), 32'(wb_ack_o), 32'd0);
            check($sformatf("rst_mid_complete%0d", i), 32'(complete_o), 32'd0);
            check($sformatf("rst_mid_dat%0d", i), wb_dat_o, 32'h0);
        end
        rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        pulse_start = -1000;
        m_exec = 1'b0; m_abort = 1'b0; m_op = '0; m_loc = '0; m_len = '0; m_pend = '0; m_en = '0;
        mon_en = 1'b1;
        check("rst_mid_irq", 32'(irq_o), 32'd0);
        rd_chk("post_rst_status", 8'h00);
        rd_chk("post_rst_op", 8'h04);
        rd_chk("post_rst_loc", 8'h08);
        rd_chk("post_rst_buf", 8'h0C);
        step(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
